// File: rtl/multicycle_ctrl.sv
`default_nettype none
//==============================================================================
// Module  : multicycle_ctrl
// Brief   : INIT/IF/ID/EX/MEM/WB sequencer for a multicycle core with a
//           retired-instruction counter. Optional IF/MEM wait watchdog is
//           compiled in with macro MULTICYCLE_CTRL_TIMEOUT_EN.
// Revision: 1.0 - initial release
//==============================================================================
module multicycle_ctrl #(
    parameter int TO_CYC = 255,
    parameter int RET_W  = 32
) (
    input  logic             clk,
    input  logic             rst,
    output logic             ifu_req,
    input  logic             ifu_rvalid,
    input  logic             is_load,
    input  logic             is_store,
    input  logic             is_ebreak,
    input  logic             wb_en,
    output logic             dmem_req,
    output logic             dmem_we,
    input  logic             dmem_ack,
    output logic             ir_we,
    output logic             reg_we,
    output logic             pc_we,
    output logic             halted,
    output logic             err,
    output logic [2:0]       state,
    output logic [RET_W-1:0] retire_cnt
);

    typedef enum logic [2:0] {
        S_INIT = 3'd0,
        S_IF   = 3'd1,
        S_ID   = 3'd2,
        S_EX   = 3'd3,
        S_MEM  = 3'd4,
        S_WB   = 3'd5,
        S_HALT = 3'd6,
        S_ERR  = 3'd7
    } state_t;

    state_t           r_state;
    logic [RET_W-1:0] r_retire_cnt;
    logic             w_timeout;
    logic             w_store;

    // A load wins when both class bits are set, so a store is store-only.
    assign w_store = is_store & ~is_load;

`ifdef MULTICYCLE_CTRL_TIMEOUT_EN
    localparam logic [15:0] C_WAIT_LAST = 16'(TO_CYC - 1);

    logic [15:0] r_wait_cnt;
    logic        w_waiting;

    assign w_waiting = ((r_state == S_IF)  && !ifu_rvalid) ||
                       ((r_state == S_MEM) && !dmem_ack);
    // Only fires on a cycle with no handshake, so a late handshake still wins.
    assign w_timeout = w_waiting && (r_wait_cnt == C_WAIT_LAST);
    assign err       = (r_state == S_ERR);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wait_cnt <= 16'd0;
        end else if (w_waiting) begin
            r_wait_cnt <= r_wait_cnt + 16'd1;
        end else begin
            r_wait_cnt <= 16'd0;
        end
    end
`else
    logic [15:0] unused_to_cyc;

    assign unused_to_cyc = 16'(TO_CYC);
    assign w_timeout     = 1'b0;
    assign err           = 1'b0;
`endif

    always_comb begin
        ifu_req  = 1'b0;
        ir_we    = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        reg_we   = 1'b0;
        pc_we    = 1'b0;
        case (r_state)
            S_IF: begin
                ifu_req = 1'b1;
                ir_we   = ifu_rvalid;
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = w_store;
                pc_we    = dmem_ack & ~is_load;
            end
            S_WB: begin
                reg_we = wb_en;
                pc_we  = 1'b1;
            end
            default: begin
                ifu_req = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_INIT;
            r_retire_cnt <= '0;
        end else begin
            if (pc_we) begin
                r_retire_cnt <= r_retire_cnt + RET_W'(1);
            end
            case (r_state)
                S_INIT: r_state <= S_IF;
                S_IF: begin
                    if (ifu_rvalid) begin
                        r_state <= S_ID;
                    end else if (w_timeout) begin
                        r_state <= S_ERR;
                    end
                end
                S_ID: r_state <= S_EX;
                S_EX: begin
                    if (is_ebreak) begin
                        r_state <= S_HALT;
                    end else if (is_load || is_store) begin
                        r_state <= S_MEM;
                    end else begin
                        r_state <= S_WB;
                    end
                end
                S_MEM: begin
                    if (dmem_ack) begin
                        r_state <= is_load ? S_WB : S_IF;
                    end else if (w_timeout) begin
                        r_state <= S_ERR;
                    end
                end
                S_WB:   r_state <= S_IF;
                S_HALT: r_state <= S_HALT;
                S_ERR:  r_state <= S_ERR;
            endcase
        end
    end

    assign halted     = (r_state == S_HALT);
    assign state      = r_state;
    assign retire_cnt = r_retire_cnt;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
//==============================================================================
// Module  : tb_multicycle_ctrl
// Brief   : Randomized instruction stream against a per-phase reference model;
//           expected outputs are queued per cycle and popped by a monitor.
// Revision: 1.0 - initial release
//==============================================================================
module tb_multicycle_ctrl;

    localparam int RET_W  = 4;
    localparam int TO_CYC = 4;
`ifdef MULTICYCLE_CTRL_TIMEOUT_EN
    localparam int MAX_DLY = 3;
`else
    localparam int MAX_DLY = 5;
`endif
    localparam int K_ALU   = 0;
    localparam int K_LOAD  = 1;
    localparam int K_STORE = 2;
    localparam int K_BOTH  = 3;
    localparam int K_EBRK  = 4;

    logic             clk;
    logic             rst;
    logic             ifu_req;
    logic             ifu_rvalid;
    logic             is_load;
    logic             is_store;
    logic             is_ebreak;
    logic             wb_en;
    logic             dmem_req;
    logic             dmem_we;
    logic             dmem_ack;
    logic             ir_we;
    logic             reg_we;
    logic             pc_we;
    logic             halted;
    logic             err;
    logic [2:0]       state;
    logic [RET_W-1:0] retire_cnt;

    multicycle_ctrl #(
        .TO_CYC (TO_CYC),
        .RET_W  (RET_W)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .ifu_req    (ifu_req),
        .ifu_rvalid (ifu_rvalid),
        .is_load    (is_load),
        .is_store   (is_store),
        .is_ebreak  (is_ebreak),
        .wb_en      (wb_en),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_ack   (dmem_ack),
        .ir_we      (ir_we),
        .reg_we     (reg_we),
        .pc_we      (pc_we),
        .halted     (halted),
        .err        (err),
        .state      (state),
        .retire_cnt (retire_cnt)
    );

    typedef struct packed {
        logic [2:0]       st;
        logic             ifu_req;
        logic             ir_we;
        logic             dmem_req;
        logic             dmem_we;
        logic             reg_we;
        logic             pc_we;
        logic             halted;
        logic             err;
        logic [RET_W-1:0] ret;
    } obs_t;

    obs_t             exp_q[$];
    logic [RET_W-1:0] m_ret;
    int               checks = 0;
    int               errors = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    always @(negedge clk) begin : monitor
        obs_t e;
        obs_t a;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {state, ifu_req, ir_we, dmem_req, dmem_we, reg_we, pc_we, halted, err, retire_cnt};
            checks = checks + 1;
            if (a !== e) begin
                errors = errors + 1;
                $display("FAIL outputs @%0t: got state=%0d vec=%b ret=%0d, expected state=%0d vec=%b ret=%0d (ifu_req,ir_we,dmem_req,dmem_we,reg_we,pc_we,halted,err)",
                         $time, a.st, a[RET_W+7:RET_W], a.ret, e.st, e[RET_W+7:RET_W], e.ret);
            end
        end
    end

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic drive(input logic r, input logic rv, input logic ack,
                         input logic ld, input logic st, input logic eb, input logic wb);
        @(posedge clk);
        #1;
        rst        = r;
        ifu_rvalid = rv;
        dmem_ack   = ack;
        is_load    = ld;
        is_store   = st;
        is_ebreak  = eb;
        wb_en      = wb;
    endtask

    // Expected outputs for the cycle just driven; halted/err follow the state.
    function automatic void exp_cycle(input logic [2:0] s, input logic ifu, input logic ir,
                                      input logic dq, input logic dw, input logic rg, input logic pc);
        obs_t e;
        e.st       = s;
        e.ifu_req  = ifu;
        e.ir_we    = ir;
        e.dmem_req = dq;
        e.dmem_we  = dw;
        e.reg_we   = rg;
        e.pc_we    = pc;
        e.halted   = (s == 3'd6);
        e.err      = (s == 3'd7);
        e.ret      = m_ret;
        exp_q.push_back(e);
        if (pc) m_ret = m_ret + RET_W'(1);
    endfunction

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b1, rb(), rb(), rb(), rb(), rb(), rb());
            m_ret = '0;
            exp_cycle(3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        drive(1'b0, rb(), rb(), rb(), rb(), rb(), rb());
        exp_cycle(3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // One instruction from IF onward: fd wait cycles before fetch data, ad before dmem_ack.
    task automatic run_instr(input int kind, input int fd, input int ad, input logic wb);
        logic ld;
        logic st;
        logic eb;
        logic fin;
        ld = (kind == K_LOAD) || (kind == K_BOTH);
        st = (kind == K_STORE) || (kind == K_BOTH);
        eb = (kind == K_EBRK);
        for (int i = 0; i <= fd; i++) begin
            fin = (i == fd);
            drive(1'b0, fin, rb(), rb(), rb(), rb(), rb());
            exp_cycle(3'd1, 1'b1, fin, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        drive(1'b0, rb(), rb(), rb(), rb(), rb(), rb());
        exp_cycle(3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, rb(), rb(), ld, st, eb, rb());
        exp_cycle(3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        if (eb) return;
        if (ld || st) begin
            for (int i = 0; i <= ad; i++) begin
                fin = (i == ad);
                drive(1'b0, rb(), fin, ld, st, 1'b0, rb());
                exp_cycle(3'd4, 1'b0, 1'b0, 1'b1, st && !ld, 1'b0, fin && !ld);
            end
        end
        if (ld || !st) begin
            drive(1'b0, rb(), rb(), ld, st, 1'b0, wb);
            exp_cycle(3'd5, 1'b0, 1'b0, 1'b0, 1'b0, wb, 1'b1);
        end
    endtask

    initial begin
        rst        = 1'b1;
        ifu_rvalid = 1'b0;
        dmem_ack   = 1'b0;
        is_load    = 1'b0;
        is_store   = 1'b0;
        is_ebreak  = 1'b0;
        wb_en      = 1'b0;
        m_ret      = '0;

        // Directed: ALU, delayed load, immediate store.
        do_reset(2);
        run_instr(K_ALU, 0, 0, 1'b1);
        run_instr(K_LOAD, 0, 3, 1'b1);
        run_instr(K_STORE, 0, 0, 1'b1);
        run_instr(K_BOTH, 1, 1, 1'b0);

        // Random stream.
        for (int n = 0; n < 60; n++) begin
            run_instr(int'($urandom_range(K_ALU, K_BOTH)), int'($urandom_range(0, MAX_DLY)),
                      int'($urandom_range(0, MAX_DLY)), rb());
        end

        // Reset mid-IF, with fetch data arriving in the reset cycle.
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 1'b0, rb(), rb(), rb(), rb(), rb());
            exp_cycle(3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        do_reset(1);

        // Counter wrap: 17 retirements on a 4-bit counter.
        for (int n = 0; n < 17; n++) begin
            run_instr(K_ALU, int'($urandom_range(0, MAX_DLY)), 0, rb());
        end

        // Reset mid-MEM with the ack in the reset cycle: no retire.
        run_instr(K_ALU, 0, 0, 1'b1);
        drive(1'b0, 1'b1, rb(), rb(), rb(), rb(), rb());
        exp_cycle(3'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, rb(), rb(), rb(), rb(), rb(), rb());
        exp_cycle(3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, rb(), rb(), 1'b0, 1'b1, 1'b0, rb());
        exp_cycle(3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, rb(), 1'b0, 1'b0, 1'b1, 1'b0, rb());
            exp_cycle(3'd4, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        end
        drive(1'b1, rb(), 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        m_ret = '0;
        exp_cycle(3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, rb(), rb(), rb(), rb(), rb(), rb());
        exp_cycle(3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // EBREAK: absorbing HALT, handshakes ignored, then reset.
        run_instr(K_ALU, 0, 0, 1'b1);
        run_instr(K_EBRK, 1, 0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, rb(), rb(), rb(), rb(), rb(), rb());
            exp_cycle(3'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        do_reset(1);

`ifdef MULTICYCLE_CTRL_TIMEOUT_EN
        // Four fetch cycles without data reach ERR; ERR is absorbing.
        for (int i = 0; i < TO_CYC; i++) begin
            drive(1'b0, 1'b0, rb(), rb(), rb(), rb(), rb());
            exp_cycle(3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, rb(), rb(), rb(), rb(), rb(), rb());
            exp_cycle(3'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        do_reset(1);
        // Handshake on the limit cycle wins, in IF and in MEM.
        run_instr(K_ALU, TO_CYC - 1, 0, 1'b1);
        run_instr(K_LOAD, 0, TO_CYC - 1, 1'b1);
        // MEM wait without ack also times out.
        run_instr(K_STORE, 0, 0, 1'b0);
        drive(1'b0, 1'b1, rb(), rb(), rb(), rb(), rb());
        exp_cycle(3'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, rb(), rb(), rb(), rb(), rb(), rb());
        exp_cycle(3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, rb(), rb(), 1'b1, 1'b0, 1'b0, rb());
        exp_cycle(3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < TO_CYC; i++) begin
            drive(1'b0, rb(), 1'b0, 1'b1, 1'b0, 1'b0, rb());
            exp_cycle(3'd4, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        end
        drive(1'b0, rb(), rb(), rb(), rb(), rb(), rb());
        exp_cycle(3'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
`else
        // No watchdog: IF waits indefinitely.
        for (int i = 0; i < 1000; i++) begin
            drive(1'b0, 1'b0, rb(), rb(), rb(), rb(), rb());
            exp_cycle(3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        run_instr(K_ALU, 0, 0, 1'b1);
`endif
        do_reset(1);
        run_instr(K_STORE, 2, 2, 1'b1);

        @(posedge clk);
        @(posedge clk);
        checks = checks + 1;
        if (exp_q.size() != 0) begin
            errors = errors + 1;
            $display("FAIL drain: got %0d pending expectations, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have parameter TO_CYC, default 255: wait-cycle limit for the timeout watchdog, legal range 1..65535.
REQ-002 SHALL have parameter RET_W, default 32: width of the retired-instruction counter.
REQ-003 SHALL have port clk  in  1: clock, all state changes on the rising edge.
REQ-004 SHALL have port rst  in  1: reset, asynchronous, active-high.
REQ-005 SHALL have ports ifu_req out 1 (fetch request) and ifu_rvalid in 1 (fetch data valid).
REQ-006 SHALL have ports is_load, is_store, is_ebreak, wb_en, each in 1: decoded instruction class and rd-write enable, sampled in EX/MEM/WB.
REQ-007 SHALL have ports dmem_req out 1, dmem_we out 1, dmem_ack in 1: data-memory handshake.
REQ-008 SHALL have ports ir_we, reg_we, pc_we, halted, err, each out 1.
REQ-009 SHALL have ports state out 3 and retire_cnt out RET_W.

Function
REQ-010 SHALL encode states as INIT=0, IF=1, ID=2, EX=3, MEM=4, WB=5, HALT=6, ERR=7, with state output driven from the state register.
REQ-011 SHALL transition INIT->IF unconditionally after one cycle.
REQ-012 SHALL assert ifu_req for every cycle spent in IF.
REQ-013 SHALL stay in IF while ifu_rvalid=0; on ifu_rvalid=1 it SHALL assert ir_we in the same cycle (combinational) and move to ID.
REQ-014 SHALL transition ID->EX unconditionally after one cycle.
REQ-015 In EX it SHALL branch with priority is_ebreak->HALT, then is_load or is_store->MEM, else ->WB; load and store both set SHALL be treated as load.
REQ-016 In MEM it SHALL assert dmem_req, and assert dmem_we = is_store & ~is_load.
REQ-017 In MEM it SHALL stay while dmem_ack=0; on dmem_ack a load SHALL go to WB, and a store SHALL assert pc_we that cycle and go to IF.
REQ-018 WB SHALL last one cycle with reg_we=wb_en and pc_we=1, then go to IF.
REQ-019 HALT SHALL be absorbing until reset, with halted=1 and all other strobes 0.
REQ-020 retire_cnt SHALL increment by 1 on every cycle with pc_we=1, wrapping modulo 2^RET_W.
REQ-021 ir_we, reg_we, pc_we, dmem_req, dmem_we, ifu_req SHALL be 0 in every state and condition not listed above.

Reset
REQ-022 While rst=1 the block SHALL be in INIT, retire_cnt=0, wait counter=0, and all outputs 0 (state=0).
REQ-023 Reset asserted mid-IF or mid-MEM SHALL abort the transaction immediately, with no pc_we or reg_we pulse.
REQ-024 The first fetch SHALL begin with ifu_req=1 on the second rising edge after rst deasserts.

Configuration
REQ-025 With macro MULTICYCLE_CTRL_TIMEOUT_EN defined, a wait counter SHALL count consecutive cycles in IF or MEM without handshake, clearing on state exit.
REQ-026 With MULTICYCLE_CTRL_TIMEOUT_EN defined, reaching TO_CYC wait cycles SHALL move the block to ERR.
REQ-027 With MULTICYCLE_CTRL_TIMEOUT_EN defined, ERR SHALL be absorbing until reset, with err=1 and all strobes 0.
REQ-028 With MULTICYCLE_CTRL_TIMEOUT_EN defined, a handshake arriving in the same cycle the limit is reached SHALL win, with normal transition and no ERR.
REQ-029 Without the macro, no wait counter SHALL exist, err SHALL be tied to 0, ERR SHALL be unreachable, and IF/MEM SHALL wait indefinitely.

Verification
REQ-030 Reset, then ifu_rvalid=1 on first IF cycle, ALU instr with wb_en=1 -> state seq 0,1,2,3,5,1; reg_we and pc_we pulse once in WB; retire_cnt=1.
REQ-031 Load with dmem_ack delayed 3 cycles -> dmem_req=1, dmem_we=0 for 4 MEM cycles; then WB with reg_we=1; retire_cnt increments once.
REQ-032 Store with immediate dmem_ack -> dmem_we=1 one cycle, pc_we=1 in MEM, reg_we never 1, next state IF.
REQ-033 is_ebreak=1 in EX -> state=6, halted=1; further ifu_rvalid/dmem_ack pulses cause no output change; rst returns state=0.
REQ-034 Timeout check: with TIMEOUT_EN and TO_CYC=4, ifu_rvalid held 0 -> state=7, err=1 after 4 IF cycles. With ifu_rvalid=1 on cycle 4 -> ID, err=0. Without macro, state stays 1 for 1000 cycles.
REQ-035 RET_W=4: retire 17 instructions -> retire_cnt=1 (wrap); assert rst mid-MEM -> no pc_we pulse, retire_cnt=0.
